// File: rtl/slave_in_pkg.sv
// rtl/slave_in_pkg.sv - shared state encoding, default widths and timeout for slave_in
package slave_in_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_CMD,
        RX_HEADER,
        RX_BEAT,
        WRITE_BEAT,
        READ_ISSUE
    } state_t;

    localparam int DEF_SLAVE_LEN = 2;
    localparam int DEF_ADDR_LEN  = 12;
    localparam int DEF_DATA_LEN  = 8;
    localparam int DEF_BURST_LEN = 12;

    localparam logic [DEF_SLAVE_LEN-1:0] DEF_SLAVE_ID = 2'b01;

    localparam int CMD_TIMEOUT = 16;
    localparam int TIMEOUT_W   = $clog2(CMD_TIMEOUT);

endpackage

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - LSB-first serial-to-parallel shifter with bit count and done flag
module serial_deserializer #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             done
);

    logic [CW-1:0] count;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '0;
            count <= '0;
            done  <= 1'b0;
        end else if (clear) begin
            data  <= '0;
            count <= '0;
            done  <= 1'b0;
        end else if (shift_en && !done) begin
            data  <= (data >> 1) | (WIDTH'(bit_in) << (WIDTH - 1));
            count <= count + CW'(1);
            done  <= (count == CW'(WIDTH - 1));
        end
    end

endmodule

// File: rtl/slave_in.sv
// rtl/slave_in.sv - serial bus slave front end: select decode, header/data receive, write and read issue
module slave_in
    import slave_in_pkg::*;
#(
    parameter int                   SLAVE_LEN = DEF_SLAVE_LEN,
    parameter int                   ADDR_LEN  = DEF_ADDR_LEN,
    parameter int                   DATA_LEN  = DEF_DATA_LEN,
    parameter int                   BURST_LEN = DEF_BURST_LEN,
    parameter logic [SLAVE_LEN-1:0] SLAVE_ID  = SLAVE_LEN'(DEF_SLAVE_ID)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bus_grant,
    input  logic                 rx_slave_select,
    input  logic                 rx_address,
    input  logic                 rx_burst_number,
    input  logic                 rx_data,
    input  logic                 master_valid,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic                 slave_ready,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic [DATA_LEN-1:0]  mem_wdata,
    output logic                 mem_we,
    output logic                 read_req,
    output logic [BURST_LEN-1:0] read_burst,
    output logic                 rx_done
);

    state_t state, state_next;

    logic                 idle_skip;
    logic                 write_mode;
    logic                 hdr_first;
    logic                 burst_flag;
    logic                 data_armed;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [BURST_LEN-1:0] beat_cnt;
    logic [BURST_LEN-1:0] beats_total;

    logic [SLAVE_LEN-1:0] sel_data;
    logic                 sel_done;
    logic [ADDR_LEN-1:0]  addr_data;
    logic                 addr_done;
    logic [BURST_LEN-1:0] burst_data;
    logic                 burst_done;
    logic [DATA_LEN-1:0]  wdata;
    logic                 data_done;

    logic                 sel_clear;
    logic                 hdr_clear;
    logic                 burst_shift;
    logic                 in_data;
    logic                 data_shift;
    logic                 header_ok;
    logic                 last_beat;
    logic [BURST_LEN-1:0] beats_hdr;
    logic                 we_go;
    logic                 rd_go;
    logic                 done_go;

    assign sel_clear   = (state != SELECT);
    assign hdr_clear   = (state == IDLE) || (state == WAIT_CMD);
    // The burst lane carries its flag on header cycle 0 and the count afterwards.
    assign burst_shift = (state == RX_HEADER) && !hdr_first && burst_flag;
    assign in_data     = ((state == RX_HEADER) && write_mode) || (state == RX_BEAT);
    assign data_shift  = in_data && data_armed;

    assign header_ok = addr_done && !hdr_first
                     && (!burst_flag || burst_done)
                     && (!write_mode || data_done);
    assign beats_hdr = (!burst_flag || (burst_data == '0)) ? BURST_LEN'(1) : burst_data;
    assign last_beat = (beat_cnt == beats_total - BURST_LEN'(1));

    serial_deserializer #(.WIDTH(SLAVE_LEN)) u_sel (
        .clk      (clk),
        .reset    (reset),
        .clear    (sel_clear),
        .shift_en (state == SELECT),
        .bit_in   (rx_slave_select),
        .data     (sel_data),
        .done     (sel_done)
    );

    serial_deserializer #(.WIDTH(ADDR_LEN)) u_addr (
        .clk      (clk),
        .reset    (reset),
        .clear    (hdr_clear),
        .shift_en (state == RX_HEADER),
        .bit_in   (rx_address),
        .data     (addr_data),
        .done     (addr_done)
    );

    serial_deserializer #(.WIDTH(BURST_LEN)) u_burst (
        .clk      (clk),
        .reset    (reset),
        .clear    (hdr_clear),
        .shift_en (burst_shift),
        .bit_in   (rx_burst_number),
        .data     (burst_data),
        .done     (burst_done)
    );

    serial_deserializer #(.WIDTH(DATA_LEN)) u_data (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_data),
        .shift_en (data_shift),
        .bit_in   (rx_data),
        .data     (wdata),
        .done     (data_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_go    = 1'b0;
        if (state != IDLE && !bus_grant) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_grant && idle_skip) state_next = SELECT;
                end
                SELECT: begin
                    if (sel_done) state_next = (sel_data == SLAVE_ID) ? WAIT_CMD : IDLE;
                end
                WAIT_CMD: begin
                    if (write_en || read_en) begin
                        state_next = RX_HEADER;
                    end else if (wait_cnt == TIMEOUT_W'(CMD_TIMEOUT - 1)) begin
                        state_next = IDLE;
                    end
                end
                RX_HEADER: begin
                    if (header_ok) state_next = write_mode ? WRITE_BEAT : READ_ISSUE;
                end
                RX_BEAT: begin
                    if (data_done) state_next = WRITE_BEAT;
                end
                WRITE_BEAT: begin
                    if (last_beat) begin
                        state_next = IDLE;
                        done_go    = 1'b1;
                    end else begin
                        state_next = RX_BEAT;
                    end
                end
                READ_ISSUE: state_next = IDLE;
                default:    state_next = IDLE;
            endcase
        end
    end

    // Pulses are registered on entry so they line up with the WRITE_BEAT / READ_ISSUE cycle.
    assign we_go = (state_next == WRITE_BEAT);
    assign rd_go = (state_next == READ_ISSUE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_skip   <= 1'b0;
            write_mode  <= 1'b0;
            hdr_first   <= 1'b0;
            burst_flag  <= 1'b0;
            data_armed  <= 1'b0;
            wait_cnt    <= '0;
            beat_cnt    <= '0;
            beats_total <= '0;
        end else begin
            idle_skip <= (state == IDLE) && bus_grant && !idle_skip;
            hdr_first <= (state == WAIT_CMD);
            wait_cnt  <= (state == WAIT_CMD) ? wait_cnt + TIMEOUT_W'(1) : '0;

            if (state == WAIT_CMD) begin
                write_mode <= write_en;
                burst_flag <= 1'b0;
                beat_cnt   <= '0;
            end else if (state == RX_HEADER && hdr_first) begin
                burst_flag <= rx_burst_number;
            end

            if (!in_data) begin
                data_armed <= 1'b0;
            end else if (master_valid) begin
                data_armed <= 1'b1;
            end

            if (state == RX_HEADER && header_ok) beats_total <= beats_hdr;
            if (state == WRITE_BEAT) beat_cnt <= beat_cnt + BURST_LEN'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slave_ready <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            read_req    <= 1'b0;
            read_burst  <= '0;
            rx_done     <= 1'b0;
        end else begin
            slave_ready <= (state_next != IDLE) && (state_next != SELECT);
            mem_we      <= we_go;
            read_req    <= rd_go;
            rx_done     <= done_go;
            if (we_go) begin
                mem_addr  <= (state == RX_HEADER) ? addr_data : mem_addr + ADDR_LEN'(1);
                mem_wdata <= wdata;
            end
            if (rd_go) begin
                mem_addr   <= addr_data;
                read_burst <= beats_hdr;
            end
        end
    end

endmodule

// File: tb/tb_slave_in.sv
// tb/tb_slave_in.sv - directed self-checking bench for slave_in
module tb_slave_in;

    logic        clk = 1'b0;
    logic        reset, bus_grant, rx_slave_select, rx_address, rx_burst_number, rx_data;
    logic        master_valid, write_en, read_en;
    logic        slave_ready, mem_we, read_req, rx_done;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [11:0] read_burst;

    int checks = 0;
    int errors = 0;
    int cyc = 0, last_we_cyc = 0, done_cyc = 0, rd_n = 0, done_n = 0, excl_bad = 0;
    logic [11:0] we_addr[$];
    logic [7:0]  we_data[$];
    int b_we, b_rd, b_dn;

    always #5 clk = ~clk;

    slave_in dut (
        .clk             (clk),
        .reset           (reset),
        .bus_grant       (bus_grant),
        .rx_slave_select (rx_slave_select),
        .rx_address      (rx_address),
        .rx_burst_number (rx_burst_number),
        .rx_data         (rx_data),
        .master_valid    (master_valid),
        .write_en        (write_en),
        .read_en         (read_en),
        .slave_ready     (slave_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .read_req        (read_req),
        .read_burst      (read_burst),
        .rx_done         (rx_done)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
            last_we_cyc <= cyc;
        end
        if (read_req) rd_n <= rd_n + 1;
        if (rx_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if ((32'(mem_we) + 32'(read_req) + 32'(rx_done)) > 1) excl_bad <= excl_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_lanes();
        rx_slave_select = 1'b0;
        rx_address      = 1'b0;
        rx_burst_number = 1'b0;
        rx_data         = 1'b0;
        master_valid    = 1'b0;
        write_en        = 1'b0;
        read_en         = 1'b0;
    endtask

    task automatic snap();
        b_we = we_addr.size();
        b_rd = rd_n;
        b_dn = done_n;
    endtask

    task automatic start(input logic [1:0] sel, input logic exp_ready);
        bus_grant = 1'b1;
        step();
        step();
        rx_slave_select = sel[0];
        step();
        rx_slave_select = sel[1];
        step();
        rx_slave_select = 1'b0;
        step();
        chk("sel_ready", 32'(slave_ready), 32'(exp_ready));
    endtask

    // ev_kind 1: drop bus_grant at header cycle ev_k; ev_kind 2: assert reset at cycle ev_k.
    task automatic header(input logic we, input logic re, input logic [11:0] addr,
                          input logic flag, input logic [11:0] n, input logic [7:0] d,
                          input int dstart, input int ev_k, input int ev_kind);
        int last;
        last = 11;
        if (flag && last < 12) last = 12;
        if (we && dstart + 8 > last) last = dstart + 8;
        write_en = we;
        read_en  = re;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k == ev_k && ev_kind == 1) bus_grant = 1'b0;
            if (k == ev_k && ev_kind == 2) begin
                chk("rst_pre_ready", 32'(slave_ready), 32'd1);
                #3 reset = 1'b0;
                #1;
                chk("rst_ready", 32'(slave_ready), 32'd0);
                chk("rst_addr", 32'(mem_addr), 32'd0);
                chk("rst_wdata", 32'(mem_wdata), 32'd0);
                chk("rst_burst", 32'(read_burst), 32'd0);
                chk("rst_we", 32'(mem_we), 32'd0);
                idle_lanes();
                bus_grant = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                break;
            end
            rx_address      = (k < 12) ? addr[k] : 1'b0;
            rx_burst_number = (k == 0) ? flag : ((flag && k <= 12) ? n[k-1] : 1'b0);
            master_valid    = (k == dstart);
            rx_data         = (k <= dstart) ? 1'b1 : ((k <= dstart + 8) ? d[k-dstart-1] : 1'b0);
            step();
        end
        idle_lanes();
    endtask

    task automatic wait_pulse(input logic rd, input string tag);
        int n;
        n = 0;
        while (!(rd ? read_req : mem_we) && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(rd ? read_req : mem_we), 32'd1);
    endtask

    task automatic beat(input logic [7:0] d, input int holds);
        idle_lanes();
        step();
        for (int h = 0; h < holds; h++) begin
            master_valid = 1'b0;
            rx_data      = 1'b1;
            step();
        end
        master_valid = 1'b1;
        rx_data      = 1'b1;
        step();
        master_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_data = d[i];
            step();
        end
        idle_lanes();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        bus_grant = 1'b0;
        idle_lanes();
        repeat (3) step();
        chk("reset_ready", 32'(slave_ready), 32'd0);
        chk("reset_we", 32'(mem_we), 32'd0);
        chk("reset_rd", 32'(read_req), 32'd0);
        chk("reset_done", 32'(rx_done), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", 32'(mem_wdata), 32'd0);
        chk("reset_rburst", 32'(read_burst), 32'd0);
        reset = 1'b1;
        step();

        // single write; write_en and read_en both high, write wins
        snap();
        start(2'b01, 1'b1);
        header(1'b1, 1'b1, 12'h0A5, 1'b0, 12'd0, 8'h3C, 0, -1, 0);
        wait_pulse(1'b0, "w1_we");
        step();
        bus_grant = 1'b0;
        step();
        step();
        chk("w1_count", 32'(we_addr.size() - b_we), 32'd1);
        chk("w1_addr", 32'(we_addr[b_we]), 32'h0A5);
        chk("w1_data", 32'(we_data[b_we]), 32'h3C);
        chk("w1_no_read", 32'(rd_n - b_rd), 32'd0);
        chk("w1_done", 32'(done_n - b_dn), 32'd1);
        chk("w1_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
        chk("w1_ready_off", 32'(slave_ready), 32'd0);

        // burst of 3 wrapping past 0xFFF, with a held marker on beat 2
        snap();
        start(2'b01, 1'b1);
        header(1'b1, 1'b0, 12'hFFF, 1'b1, 12'd3, 8'h11, 0, -1, 0);
        wait_pulse(1'b0, "b_we0");
        beat(8'h22, 2);
        wait_pulse(1'b0, "b_we1");
        beat(8'h33, 0);
        wait_pulse(1'b0, "b_we2");
        step();
        bus_grant = 1'b0;
        step();
        step();
        chk("b_count", 32'(we_addr.size() - b_we), 32'd3);
        chk("b_addr0", 32'(we_addr[b_we]), 32'hFFF);
        chk("b_data0", 32'(we_data[b_we]), 32'h11);
        chk("b_addr1", 32'(we_addr[b_we+1]), 32'h000);
        chk("b_data1", 32'(we_data[b_we+1]), 32'h22);
        chk("b_addr2", 32'(we_addr[b_we+2]), 32'h001);
        chk("b_data2", 32'(we_data[b_we+2]), 32'h33);
        chk("b_done", 32'(done_n - b_dn), 32'd1);
        chk("b_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);

        // select mismatch
        snap();
        start(2'b10, 1'b0);
        bus_grant = 1'b0;
        repeat (6) step();
        chk("ns_ready", 32'(slave_ready), 32'd0);
        chk("ns_pulses", 32'(we_addr.size() - b_we + rd_n - b_rd + done_n - b_dn), 32'd0);

        // read, burst 5
        snap();
        start(2'b01, 1'b1);
        header(1'b0, 1'b1, 12'h123, 1'b1, 12'd5, 8'h00, 0, -1, 0);
        wait_pulse(1'b1, "rd_req");
        chk("rd_addr", 32'(mem_addr), 32'h123);
        chk("rd_burst", 32'(read_burst), 32'd5);
        step();
        chk("rd_ready_off", 32'(slave_ready), 32'd0);
        chk("rd_req_single", 32'(read_req), 32'd0);
        bus_grant = 1'b0;
        step();
        chk("rd_count", 32'(rd_n - b_rd), 32'd1);
        chk("rd_no_we", 32'(we_addr.size() - b_we), 32'd0);

        // command timeout
        snap();
        start(2'b01, 1'b1);
        repeat (15) step();
        chk("to_ready_15", 32'(slave_ready), 32'd1);
        step();
        chk("to_ready_16", 32'(slave_ready), 32'd0);
        bus_grant = 1'b0;
        repeat (3) step();
        chk("to_pulses", 32'(we_addr.size() - b_we + rd_n - b_rd + done_n - b_dn), 32'd0);

        // grant dropped mid-data
        snap();
        start(2'b01, 1'b1);
        header(1'b1, 1'b0, 12'h055, 1'b0, 12'd0, 8'hFF, 0, 5, 1);
        repeat (20) step();
        chk("gd_no_we", 32'(we_addr.size() - b_we), 32'd0);
        chk("gd_no_done", 32'(done_n - b_dn), 32'd0);
        chk("gd_ready", 32'(slave_ready), 32'd0);

        // reset mid-beat, then a clean write with a late first-beat marker
        snap();
        start(2'b01, 1'b1);
        header(1'b1, 1'b0, 12'h2B7, 1'b0, 12'd0, 8'hA5, 0, 4, 2);
        repeat (2) step();
        chk("rst_no_we", 32'(we_addr.size() - b_we), 32'd0);
        snap();
        start(2'b01, 1'b1);
        header(1'b1, 1'b0, 12'h3C0, 1'b0, 12'd0, 8'h5A, 2, -1, 0);
        wait_pulse(1'b0, "rc_we");
        step();
        bus_grant = 1'b0;
        step();
        step();
        chk("rc_count", 32'(we_addr.size() - b_we), 32'd1);
        chk("rc_addr", 32'(we_addr[b_we]), 32'h3C0);
        chk("rc_data", 32'(we_data[b_we]), 32'h5A);
        chk("rc_done", 32'(done_n - b_dn), 32'd1);

        chk("exclusive", 32'(excl_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
